qsub_pipe: RTL and testbench
============================

// Module: qsub_pipe
// PURPOSE
//   Pipelined sign-magnitude Q-format fixed-point subtractor: c = a - b.
//   Companion to the combinational sign-magnitude adder in the arithmetic library.
//   Registered 2-stage datapath with valid/ready handshakes on both sides and an overflow flag.
//   Sits between operand producers and consumers in the fixed-point datapath.
// PARAMETERS
//   Q  15  fractional bits (documentation/bench scaling only; datapath is Q-agnostic)
//   N  32  total width; bit N-1 = sign, bits N-2:0 = magnitude
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand pair a,b valid
//   in_ready   out  1  block accepts operands this cycle
//   a          in   N  minuend, sign-magnitude
//   b          in   N  subtrahend, sign-magnitude
//   out_valid  out  1  c/ovf valid
//   out_ready  in   1  consumer accepts result this cycle
//   c          out  N  difference, sign-magnitude
//   ovf        out  1  magnitude overflowed N-1 bits
// BEHAVIOUR
//   Reset (async assert, sync release): out_valid=0, c=0, ovf=0, stage-1 valid cleared; in-flight data discarded.
//   Transfer: in on in_valid&in_ready; out on out_valid&out_ready.
//   Stage 1 (on accept): sb = ~b[N-1]; register a_sign, sb, am=a[N-2:0], bm=b[N-2:0], a_gt=(am>bm), same=(a_sign==sb).
//   Stage 2: same -> sum = am+bm (N bits), mag=sum[N-2:0], sign=a_sign, ovf=sum[N-1].
//            differ & a_gt -> mag=am-bm, sign=a_sign; differ & !a_gt -> mag=bm-am, sign=sb; ovf=0.
//   Zero result always has sign 0 (no -0 output); -0 inputs are treated as magnitude 0.
//   Latency 2 cycles from accept to out_valid; throughput 1 result/cycle when out_ready=1.
//   Flow: adv2 = ~out_valid | out_ready; in_ready = ~s1_valid | adv2 (combinational, no bubble).
//   Stall: while out_valid & ~out_ready, c/ovf/out_valid held stable; stage 1 holds; in_ready=0 once s1 full.
//   Simultaneous out handshake and new accept: both occur in the same cycle, no data loss or duplication.
// CONFIGURATION
//   QSUB_SATURATE_EN defined: on ovf=1, mag clamps to all-ones (2^(N-1)-1); sign kept; ovf still reported.
//   Undefined: on ovf=1, mag wraps (carry dropped), matching the library adder; ovf still reported.
// STRUCTURE
//   Package qfix_pkg: N/Q defaults, sign-magnitude typedef {sign, mag}, SM_ZERO and SM_MAX_MAG constants.
//   Sub-module qsm_magunit: combinational magnitude add/sub + sign/zero-normalisation, instantiated in stage 2.
// TESTING  (N=32, Q=15; 1.0 = 0x00008000)
//   a=0x00018000 (+3), b=0x00008000 (+1) -> c=0x00010000 (+2), ovf=0, out_valid 2 cycles after accept.
//   a=0x00008000 (+1), b=0x00018000 (+3) -> c=0x80010000 (-2), ovf=0.
//   a=0x80010000 (-2), b=0x80010000 (-2) -> c=0x00000000 (+0, sign 0), ovf=0.
//   a=0x7FFFFFFF, b=0x80000001 -> ovf=1; c=0x00000000 without QSUB_SATURATE_EN, 0x7FFFFFFF with it.
//   Stream 8 pairs, out_ready low cycles 3-5 -> in_ready drops, c held stable, all 8 results in order, none lost.
//   Assert rst_n low with 2 ops in flight -> out_valid=0, c=0 immediately; first post-reset result correct.

Source files
------------

// File: rtl/qfix_pkg.sv
// Shared Q-format fixed-point definitions for the sign-magnitude datapath.
// Holds default widths, the {sign, mag} word type and common constants.
package qfix_pkg;

    localparam int QF_N = 32;
    localparam int QF_Q = 15;

    typedef struct packed {
        logic              sign;
        logic [QF_N-2:0]   mag;
    } sm_t;

    localparam sm_t SM_ZERO = '{sign: 1'b0, mag: '0};
    localparam logic [QF_N-2:0] SM_MAX_MAG = {(QF_N-1){1'b1}};

endpackage

// File: rtl/qsm_magunit.sv
// Combinational sign-magnitude magnitude add/subtract with sign selection,
// zero-sign normalisation and overflow (wrap, or clamp if QSUB_SATURATE_EN).
// Ports: a_sign/b_sign operand signs, am/bm magnitudes, a_gt (am>bm),
//        same (signs equal); c result word, ovf magnitude carry-out.
import qfix_pkg::*;

module qsm_magunit #(
    parameter int N = QF_N
) (
    input  logic         a_sign,
    input  logic         b_sign,
    input  logic [N-2:0] am,
    input  logic [N-2:0] bm,
    input  logic         a_gt,
    input  logic         same,
    output logic [N-1:0] c,
    output logic         ovf
);

    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sign;

    always_comb begin
        sum  = {1'b0, am} + {1'b0, bm};
        mag  = '0;
        sign = 1'b0;
        ovf  = 1'b0;
        if (same) begin
            mag  = sum[N-2:0];
            sign = a_sign;
            ovf  = sum[N-1];
`ifdef QSUB_SATURATE_EN
            if (sum[N-1]) begin
                mag = {(N-1){1'b1}};
            end
`endif
        end else if (a_gt) begin
            mag  = am - bm;
            sign = a_sign;
        end else begin
            mag  = bm - am;
            sign = b_sign;
        end
        // never emit -0, including a wrapped-to-zero overflow
        if (mag == '0) begin
            sign = 1'b0;
        end
        c = {sign, mag};
    end

endmodule

// File: rtl/qsub_pipe.sv
// Two-stage pipelined sign-magnitude subtractor c = a - b with valid/ready
// on both sides. Ports: clk, rst_n, in_valid/in_ready/a/b, out_valid/
// out_ready/c/ovf. Build macro QSUB_SATURATE_EN clamps on overflow.
import qfix_pkg::*;

module qsub_pipe #(
    parameter int Q = QF_Q,
    parameter int N = QF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    if (Q >= N - 1) begin : g_q_range
        $error("Q must leave at least one integer bit");
    end

    logic         s1_valid_q, s1_valid_d;
    logic         a_sign_q, a_sign_d;
    logic         sb_q, sb_d;
    logic [N-2:0] am_q, am_d;
    logic [N-2:0] bm_q, bm_d;
    logic         a_gt_q, a_gt_d;
    logic         same_q, same_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] c_q, c_d;
    logic         ovf_q, ovf_d;
    logic         adv2;
    logic [N-1:0] mu_c;
    logic         mu_ovf;

    qsm_magunit #(.N(N)) u_mag (
        .a_sign (a_sign_q),
        .b_sign (sb_q),
        .am     (am_q),
        .bm     (bm_q),
        .a_gt   (a_gt_q),
        .same   (same_q),
        .c      (mu_c),
        .ovf    (mu_ovf)
    );

    always_comb begin
        adv2        = ~out_valid_q | out_ready;
        in_ready    = ~s1_valid_q | adv2;
        s1_valid_d  = s1_valid_q;
        a_sign_d    = a_sign_q;
        sb_d        = sb_q;
        am_d        = am_q;
        bm_d        = bm_q;
        a_gt_d      = a_gt_q;
        same_d      = same_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            // subtract by adding b with its sign flipped
            a_sign_d = a[N-1];
            sb_d     = ~b[N-1];
            am_d     = a[N-2:0];
            bm_d     = b[N-2:0];
            a_gt_d   = a[N-2:0] > b[N-2:0];
            same_d   = a[N-1] == ~b[N-1];
        end
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d   = mu_c;
                ovf_d = mu_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_sign_q    <= 1'b0;
            sb_q        <= 1'b0;
            am_q        <= '0;
            bm_q        <= '0;
            a_gt_q      <= 1'b0;
            same_q      <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_sign_q    <= a_sign_d;
            sb_q        <= sb_d;
            am_q        <= am_d;
            bm_q        <= bm_d;
            a_gt_q      <= a_gt_d;
            same_q      <= same_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_qsub_pipe.sv
// Self-checking bench for qsub_pipe: directed vectors, stall, reset and
// random traffic against a signed-integer reference with a result queue.
module tb_qsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic        stall_prev = 1'b0;
    logic [31:0] held_c = '0;
    int          n_in = 0;
    int          n_out = 0;

    qsub_pipe #(.Q(15), .N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // difference of two signed integers, then re-encoded as sign-magnitude
    function automatic logic [32:0] ref_sub(input logic [31:0] x,
                                            input logic [31:0] y);
        longint vx, vy, d, m;
        logic [30:0] mag;
        logic        o, s;
        vx = longint'({1'b0, x[30:0]});
        vy = longint'({1'b0, y[30:0]});
        if (x[31]) vx = -vx;
        if (y[31]) vy = -vy;
        d = vx - vy;
        m = (d < 0) ? -d : d;
        o = m > 64'sh7FFF_FFFF;
        mag = m[30:0];
`ifdef QSUB_SATURATE_EN
        if (o) mag = 31'h7FFF_FFFF;
`endif
        s = (d < 0) && (mag != 0);
        return {o, s, mag};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v[30:0] = 31'h7FFF_FFFF;
            1: v[30:0] = '0;
            2: v[30:0] = v[30:0] >> 16;
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] av,
                        input logic [31:0] bv, input logic ordy);
        logic [32:0] e;
        in_valid  = iv;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_c", 64'(c), 64'(held_c));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("c", 64'(c), 64'(e[31:0]));
                chk("ovf", 64'(ovf), 64'(e[32]));
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_sub(av, bv));
            n_in++;
        end
        stall_prev = out_valid && !out_ready;
        held_c     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] c_exp,
                           input logic ovf_exp);
        step(1'b1, av, bv, 1'b1);
        chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
        step(1'b0, '0, '0, 1'b1);
        chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
        chk({tag, "_c"}, 64'(c), 64'(c_exp));
        chk({tag, "_ovf"}, 64'(ovf), 64'(ovf_exp));
        step(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        logic [31:0] ovf_c;
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_c", 64'(c), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("p3m1", 32'h0001_8000, 32'h0000_8000, 32'h0001_0000, 1'b0);
        run_one("p1m3", 32'h0000_8000, 32'h0001_8000, 32'h8001_0000, 1'b0);
        run_one("zero", 32'h8001_0000, 32'h8001_0000, 32'h0000_0000, 1'b0);
`ifdef QSUB_SATURATE_EN
        ovf_c = 32'h7FFF_FFFF;
`else
        ovf_c = 32'h0000_0000;
`endif
        run_one("ovf", 32'h7FFF_FFFF, 32'h8000_0001, ovf_c, 1'b1);
        run_one("negz", 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);

        // stream of 8 with the consumer stalled on cycles 3-5
        n_in  = 0;
        n_out = 0;
        t     = 0;
        while (n_out < 8 && t < 40) begin
            if (t == 4) chk("stall_in_ready", 64'(in_ready), 64'd0);
            step(n_in < 8, rnd_op(), rnd_op(), !(t >= 3 && t <= 5));
            t++;
        end
        chk("stream_count", 64'(n_out), 64'd8);
        chk("stream_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // reset with two operations in flight
        step(1'b1, rnd_op(), rnd_op(), 1'b1);
        step(1'b1, rnd_op(), rnd_op(), 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_c", 64'(c), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_one("postrst", 32'h0001_8000, 32'h0000_8000, 32'h0001_0000, 1'b0);
        exp_q.delete();

        // random traffic with random back-pressure
        n_in  = 0;
        n_out = 0;
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(),
                 $urandom_range(0, 2) != 0);
        end
        t = 0;
        while (exp_q.size() != 0 && t < 20) begin
            step(1'b0, '0, '0, 1'b1);
            t++;
        end
        chk("rand_drain", 64'(exp_q.size()), 64'd0);
        chk("rand_count", 64'(n_out), 64'(n_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
